prbs_checker: RTL and testbench
===============================

# prbs_checker

Self-synchronising checker for the 8-bit LFSR word stream produced by the team's LFSR generator: next = {s[4]^s[3]^s[2]^s[0], s[7:1]}. It sits at the receive end of a link carrying one LFSR state per valid cycle. It acquires lock by seeding from the incoming data, then predicts every subsequent word from its own state. It flags and counts mismatches, and drops lock after a run of consecutive errors. It is used for link/bring-up testing and as the verification partner of the generator.

## Interface
- LOCK_CNT, 4: consecutive correct predictions required in HUNT before declaring lock (1..15).
- LOSS_CNT, 3: consecutive mismatches in LOCKED that force return to HUNT (1..15).
- CNT_W, 16: width of err_cnt and word_cnt.
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  in_data holds a word this cycle.
- in_data  input  8  received LFSR word.
- clr_cnt  input  1  synchronous clear of err_cnt and word_cnt.
- locked  output  1  checker is in LOCKED state (registered).
- err_pulse  output  1  one-cycle pulse, mismatch detected on the previous valid word.
- err_cnt  output  CNT_W  saturating count of mismatches while LOCKED.
- word_cnt  output  CNT_W  saturating count of valid words checked while LOCKED.

## Operation
- Internal state: `exp[7:0]` holds the expected next word. `seeded` flag. `match_cnt[3:0]`. `miss_cnt[3:0]`. FSM with states HUNT and LOCKED.
- The next function is nxt(s) = {s[4]^s[3]^s[2]^s[0], s[7:1]}.
- Only cycles with in_valid=1 advance anything. When in_valid=0, all state holds and err_pulse=0.
- HUNT, seeded=0:
  - A nonzero word sets exp=nxt(in_data), seeded=1, match_cnt=0.
  - A zero word is ignored (the all-zero state is a lock-up state).
- HUNT, seeded=1:
  - If in_data==exp: exp=nxt(in_data) and match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt=0.
  - If in_data!=exp and nonzero: reseed with exp=nxt(in_data), match_cnt=0.
  - If in_data!=exp and zero: seeded=0, match_cnt=0.
  - No errors are counted in HUNT.
- LOCKED:
  - exp=nxt(exp) on every valid word, whether or not the word matched. The internal reference never re-syncs to the data.
  - word_cnt increments on every valid word, saturating at all-ones.
  - On a match, miss_cnt=0.
  - On a mismatch: err_pulse=1 next cycle, err_cnt increments (saturating), miss_cnt++.
  - When miss_cnt reaches LOSS_CNT, go to HUNT with seeded=0 and match_cnt=0. The word that triggered the loss is still counted as an error.
- clr_cnt=1 zeroes err_cnt and word_cnt. It has priority over a same-cycle increment. It does not affect FSM, exp or locked.
- Reset values: FSM=HUNT, seeded=0, exp=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_cnt=0, word_cnt=0.

## Timing
- Registered outputs; latency is 1 cycle from the sampling edge of a valid word to its effect on locked, err_pulse and the counters.
- locked rises 1 cycle after the edge that samples the LOCK_CNT-th consecutive match. With defaults this is the 5th valid word: seed plus 4 matches.
- locked falls 1 cycle after the edge sampling the LOSS_CNT-th consecutive mismatch. The err_pulse for that word appears in the same cycle.
- Idle gaps (in_valid=0) between words are transparent: they change neither lock progress nor miss runs.
- rst asserted at any time, including mid-lock, clears every register immediately without waiting for clk. The first edge after rst deasserts may sample data.
- Back-to-back valid words every cycle are supported; there is no backpressure.

## Test plan
- Lock acquisition: after reset, drive 01,80,40,20,10 on consecutive cycles -> locked=1 one cycle after 0x10 is sampled. err_cnt=0, word_cnt=0.
- Single error: once locked, drive 0x89 in place of 0x88 -> one err_pulse, err_cnt=1, locked stays 1. Then drive C4 -> no error (exp advanced internally from 0x88). word_cnt=2.
- Loss of lock: once locked, drive three consecutive wrong words (0x00, 0x55, 0x55) -> err_cnt=3, three err_pulses, locked=0 one cycle after the third.
- Zero/reseed in HUNT: drive 00,00,10,88,C4 -> the zeros are ignored, 0x10 seeds, and lock needs 4 matches after 0x10. Inserting 0x33 mid-hunt restarts the count from 0x33.
- Saturation and clear: with CNT_W=4, drive 20 errors while keeping lock by alternating correct/incorrect words -> err_cnt holds 15. Assert clr_cnt in the same cycle as an error -> err_cnt=0.
- Async reset mid-lock: pulse rst between clk edges while locked -> locked, err_cnt and word_cnt are 0 before the next edge. Relock requires the full seed plus LOCK_CNT sequence.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising receive-side checker for the 8-bit LFSR
// word stream. It seeds its reference from the incoming data while hunting,
// then predicts each word on its own once locked. It counts words and
// mismatches while locked, and drops lock after a run of consecutive errors.
//
//   state     | meaning
//   ST_HUNT   | seeding from data, counting consecutive correct predictions
//   ST_LOCKED | free-running reference, checking and counting every word
module prbs_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_TGT = 4'(LOSS_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       exp_q, exp_d;
  logic             seeded_q, seeded_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  // Generator step: feedback tap into bit 7, shift right.
  function automatic logic [7:0] lfsr_nxt(input logic [7:0] s);
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

  logic       data_match;
  logic       data_zero;
  logic [7:0] nxt_data;
  logic [7:0] nxt_exp;
  logic [3:0] match_inc;
  logic [3:0] miss_inc;
  logic       err_sat;
  logic       word_sat;

  assign data_match = (in_data == exp_q);
  assign data_zero  = (in_data == 8'h00);
  assign nxt_data   = lfsr_nxt(in_data);
  assign nxt_exp    = lfsr_nxt(exp_q);
  assign match_inc  = match_cnt_q + 4'd1;
  assign miss_inc   = miss_cnt_q + 4'd1;
  assign err_sat    = &err_cnt_q;
  assign word_sat   = &word_cnt_q;

  // Next-state logic: only valid words advance anything; counter clear wins.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    seeded_d    = seeded_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;

    if (in_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (!seeded_q) begin
            // All-zero is the LFSR lock-up state and can never seed.
            if (!data_zero) begin
              exp_d       = nxt_data;
              seeded_d    = 1'b1;
              match_cnt_d = 4'd0;
            end
          end else if (data_match) begin
            exp_d       = nxt_data;
            match_cnt_d = match_inc;
            if (match_inc == LOCK_TGT) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = 4'd0;
            end
          end else if (!data_zero) begin
            exp_d       = nxt_data;
            match_cnt_d = 4'd0;
          end else begin
            seeded_d    = 1'b0;
            match_cnt_d = 4'd0;
          end
        end

        ST_LOCKED: begin
          // Reference free-runs; a bad word must not corrupt the prediction.
          exp_d = nxt_exp;
          if (!word_sat) begin
            word_cnt_d = word_cnt_q + CNT_ONE;
          end
          if (data_match) begin
            miss_cnt_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            if (!err_sat) begin
              err_cnt_d = err_cnt_q + CNT_ONE;
            end
            miss_cnt_d = miss_inc;
            if (miss_inc == LOSS_TGT) begin
              state_d     = ST_HUNT;
              seeded_d    = 1'b0;
              match_cnt_d = 4'd0;
            end
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end

    if (clr_cnt) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      exp_q       <= 8'h00;
      seeded_q    <= 1'b0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      seeded_q    <= seeded_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a default instance plus a 4-bit-counter
// instance share one stimulus stream so saturation is seen on the narrow one.
module tb_prbs_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr_cnt;

  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [15:0] word_cnt;

  logic        locked_w4;
  logic        err_pulse_w4;
  logic [3:0]  err_cnt_w4;
  logic [3:0]  word_cnt_w4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] gen;

  prbs_checker u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt)
  );

  prbs_checker #(.CNT_W(4)) u_dut_w4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_cnt   (clr_cnt),
    .locked    (locked_w4),
    .err_pulse (err_pulse_w4),
    .err_cnt   (err_cnt_w4),
    .word_cnt  (word_cnt_w4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  // Hand-checked chain 01->80->40->20->10->88->C4->E2->71->38 uses this step.
  function automatic logic [7:0] lfsr_nxt(input logic [7:0] s);
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_good();
    push(gen);
    gen = lfsr_nxt(gen);
  endtask

  task automatic push_bad();
    push(gen ^ 8'h01);
    gen = lfsr_nxt(gen);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_idle();
    in_valid = 1'b0;
    clr_cnt  = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt  = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clr_cnt  = 1'b0;
    gen      = 8'h00;

    #12;
    check_eq("rst_locked", locked, 0);
    check_eq("rst_err_pulse", err_pulse, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_word_cnt", word_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Lock acquisition: seed plus four matches.
    push(8'h01);
    push(8'h80);
    push(8'h40);
    push(8'h20);
    check_eq("acq_not_yet", locked, 0);
    push(8'h10);
    check_eq("acq_locked", locked, 1);
    check_eq("acq_err_cnt", err_cnt, 0);
    check_eq("acq_word_cnt", word_cnt, 0);

    // Single error, then the reference continues from 0x88.
    push(8'h89);
    check_eq("err1_pulse", err_pulse, 1);
    check_eq("err1_err_cnt", err_cnt, 1);
    check_eq("err1_locked", locked, 1);
    push(8'hC4);
    check_eq("err1_next_pulse", err_pulse, 0);
    check_eq("err1_next_err_cnt", err_cnt, 1);
    check_eq("err1_word_cnt", word_cnt, 2);
    idle(3);
    check_eq("idle_word_cnt", word_cnt, 2);
    check_eq("idle_pulse", err_pulse, 0);

    // Loss of lock: three consecutive wrong words, with a gap inside the run.
    clear_idle();
    check_eq("clr_err_cnt", err_cnt, 0);
    check_eq("clr_locked", locked, 1);
    push(8'h00);
    check_eq("loss1_pulse", err_pulse, 1);
    idle(2);
    check_eq("loss_gap_pulse", err_pulse, 0);
    push(8'h55);
    check_eq("loss2_locked", locked, 1);
    push(8'h55);
    check_eq("loss3_locked", locked, 0);
    check_eq("loss3_pulse", err_pulse, 1);
    check_eq("loss3_err_cnt", err_cnt, 3);
    check_eq("loss3_word_cnt", word_cnt, 3);

    // Hunt: zeros ignored, 0x10 seeds, 0x33 restarts the match count.
    push(8'h00);
    push(8'h00);
    push(8'h10);
    push(8'h88);
    push(8'hC4);
    push(8'h33);
    check_eq("hunt_no_lock", locked, 0);
    check_eq("hunt_err_cnt", err_cnt, 3);
    gen = 8'h19;
    push_good();
    push_good();
    push_good();
    check_eq("hunt_3_matches", locked, 0);
    push_good();
    check_eq("hunt_relock", locked, 1);
    check_eq("hunt_word_cnt", word_cnt, 3);

    // Saturation: 20 errors alternating with good words keeps lock.
    clear_idle();
    check_eq("sat_clr_w4", err_cnt_w4, 0);
    repeat (20) begin
      push_bad();
      push_good();
    end
    check_eq("sat_locked", locked, 1);
    check_eq("sat_err_cnt16", err_cnt, 20);
    check_eq("sat_word_cnt16", word_cnt, 40);
    check_eq("sat_err_cnt_w4", err_cnt_w4, 15);
    check_eq("sat_word_cnt_w4", word_cnt_w4, 15);
    check_eq("sat_locked_w4", locked_w4, 1);

    // Clear wins over a same-cycle error increment.
    clr_cnt = 1'b1;
    push_bad();
    clr_cnt = 1'b0;
    check_eq("clrerr_err_cnt", err_cnt, 0);
    check_eq("clrerr_err_cnt_w4", err_cnt_w4, 0);
    check_eq("clrerr_word_cnt", word_cnt, 0);
    check_eq("clrerr_pulse", err_pulse, 1);
    check_eq("clrerr_locked", locked, 1);
    push_good();
    check_eq("post_clr_err_cnt", err_cnt, 0);
    check_eq("post_clr_word_cnt", word_cnt, 1);

    // Asynchronous reset between edges while locked.
    push_bad();
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_locked", locked, 0);
    check_eq("arst_err_cnt", err_cnt, 0);
    check_eq("arst_word_cnt", word_cnt, 0);
    check_eq("arst_pulse", err_pulse, 0);
    #1;
    rst = 1'b0;

    // Relock needs the full seed plus four matches; gaps are transparent.
    push(8'h01);
    push(8'h80);
    idle(2);
    push(8'h40);
    push(8'h20);
    check_eq("relock_not_yet", locked, 0);
    push(8'h10);
    check_eq("relock_locked", locked, 1);
    check_eq("relock_err_cnt", err_cnt, 0);
    push(8'h88);
    check_eq("relock_word_cnt", word_cnt, 1);
    check_eq("relock_pulse", err_pulse, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
